minefield_ctrl: RTL and testbench

- Game-state engine for the 8x8 minesweeper board.
- Sits directly upstream of the board renderer. Owns and drives the four 64-bit tile maps (mine, flag, step, cursor position) that the renderer samples every pixel.
- Places mines pseudo-randomly at game start, applies single-cycle player commands, and detects win or loss.
- Tile index t = {row[2:0], col[2:0]}: bits [5:3] are the row (0 = top), bits [2:0] are the column (0 = left).

---
 rtl/minesweeper_pkg.sv | 21 ++
 rtl/lfsr16.sv | 37 +++
 rtl/minefield_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_minefield_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper game engine and board renderer:
// board geometry, game-state encodings and the LFSR feedback mask.
package minesweeper_pkg;

  localparam int unsigned BOARD_TILES = 64;
  localparam int unsigned BOARD_DIM   = 8;
  localparam int unsigned IDX_W       = $clog2(BOARD_TILES);
  localparam int unsigned RC_W        = $clog2(BOARD_DIM);
  localparam int unsigned CNT_W       = 7;
  localparam int unsigned LFSR_W      = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    GS_GEN  = 2'd0,
    GS_PLAY = 2'd1,
    GS_LOST = 2'd2,
    GS_WON  = 2'd3
  } game_state_e;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR.
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset; loads seed
//   seed  - value loaded during reset (must be non-zero)
//   out   - current LFSR state
module lfsr16
  import minesweeper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift right; when the bit shifted out is 1, fold the feedback mask in.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/minefield_ctrl.sv
// Game-state engine for the 8x8 minesweeper board. Places mines from a
// free-running LFSR, applies one player command per cycle and detects
// win/loss. All outputs are registered.
// Ports:
//   clk, reset              - clock, synchronous active-low reset
//   new_game                - pulse: abandon game, regenerate the board
//   cmd_up/down/left/right  - cursor move pulses (wrap within the board)
//   cmd_flag, cmd_step      - toggle flag / reveal tile at the cursor
//   mineMap, flagMap,
//   stepMap, posMap         - 64-bit tile maps, tile t = {row, col}
//   game_state              - GEN=0, PLAY=1, LOST=2, WON=3
//   busy                    - high while generating
//   flag_count              - number of flagged tiles
module minefield_ctrl
  import minesweeper_pkg::*;
#(
  parameter int unsigned       NUM_MINES = 10,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   cmd_up,
  input  logic                   cmd_down,
  input  logic                   cmd_left,
  input  logic                   cmd_right,
  input  logic                   cmd_flag,
  input  logic                   cmd_step,
  output logic [BOARD_TILES-1:0] mineMap,
  output logic [BOARD_TILES-1:0] flagMap,
  output logic [BOARD_TILES-1:0] stepMap,
  output logic [BOARD_TILES-1:0] posMap,
  output logic [1:0]             game_state,
  output logic                   busy,
  output logic [CNT_W-1:0]       flag_count
);

  localparam logic [CNT_W-1:0] SAFE_INIT   = CNT_W'(BOARD_TILES - NUM_MINES);
  localparam logic [CNT_W-1:0] MINE_TARGET = CNT_W'(NUM_MINES);

  game_state_e            state_q, state_d;
  logic                   busy_q, busy_d;
  logic [BOARD_TILES-1:0] mine_q, mine_d;
  logic [BOARD_TILES-1:0] flag_q, flag_d;
  logic [BOARD_TILES-1:0] step_q, step_d;
  logic [BOARD_TILES-1:0] pos_map_q, pos_map_d;
  logic [IDX_W-1:0]       pos_idx_q, pos_idx_d;
  logic [CNT_W-1:0]       flag_cnt_q, flag_cnt_d;
  logic [CNT_W-1:0]       placed_q, placed_d;
  logic [CNT_W-1:0]       safe_q, safe_d;

  logic [LFSR_W-1:0]      lfsr_w;
  logic [IDX_W-1:0]       cand_c;
  logic                   lfsr_unused_c;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (lfsr_w)
  );

  // Only the low bits pick a tile; the rest of the LFSR state is internal.
  assign cand_c        = lfsr_w[IDX_W-1:0];
  assign lfsr_unused_c = ^lfsr_w[LFSR_W-1:IDX_W];

  // Cursor move with per-axis wrap; priority up > down > left > right.
  function automatic logic [IDX_W-1:0] move_cursor(
    input logic [IDX_W-1:0] idx,
    input logic             up,
    input logic             dn,
    input logic             lf,
    input logic             rt
  );
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    row = idx[IDX_W-1:RC_W];
    col = idx[RC_W-1:0];
    if (up) begin
      row = row - RC_W'(1);
    end else if (dn) begin
      row = row + RC_W'(1);
    end else if (lf) begin
      col = col - RC_W'(1);
    end else if (rt) begin
      col = col + RC_W'(1);
    end
    return {row, col};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= GS_GEN;
      busy_q     <= 1'b1;
      mine_q     <= '0;
      flag_q     <= '0;
      step_q     <= '0;
      pos_idx_q  <= '0;
      pos_map_q  <= BOARD_TILES'(1);
      flag_cnt_q <= '0;
      placed_q   <= '0;
      safe_q     <= SAFE_INIT;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      mine_q     <= mine_d;
      flag_q     <= flag_d;
      step_q     <= step_d;
      pos_idx_q  <= pos_idx_d;
      pos_map_q  <= pos_map_d;
      flag_cnt_q <= flag_cnt_d;
      placed_q   <= placed_d;
      safe_q     <= safe_d;
    end
  end

  // Next-state: new_game overrides everything, then per-state handling.
  always_comb begin
    state_d    = state_q;
    mine_d     = mine_q;
    flag_d     = flag_q;
    step_d     = step_q;
    pos_idx_d  = pos_idx_q;
    flag_cnt_d = flag_cnt_q;
    placed_d   = placed_q;
    safe_d     = safe_q;

    if (new_game) begin
      state_d    = GS_GEN;
      mine_d     = '0;
      flag_d     = '0;
      step_d     = '0;
      pos_idx_d  = '0;
      flag_cnt_d = '0;
      placed_d   = '0;
      safe_d     = SAFE_INIT;
    end else begin
      unique case (state_q)
        GS_GEN: begin
          // Duplicate candidates are skipped; the LFSR moves on regardless.
          if (placed_q == MINE_TARGET) begin
            state_d = GS_PLAY;
          end else if (!mine_q[cand_c]) begin
            mine_d[cand_c] = 1'b1;
            placed_d       = placed_q + CNT_W'(1);
          end
        end
        GS_PLAY: begin
          if (cmd_step) begin
            if (!step_q[pos_idx_q] && !flag_q[pos_idx_q]) begin
              if (mine_q[pos_idx_q]) begin
                step_d  = step_q | mine_q;
                state_d = GS_LOST;
              end else begin
                step_d[pos_idx_q] = 1'b1;
                safe_d            = safe_q - CNT_W'(1);
                if (safe_q == CNT_W'(1)) begin
                  state_d = GS_WON;
                end
              end
            end
          end else if (cmd_flag) begin
            if (!step_q[pos_idx_q]) begin
              flag_d[pos_idx_q] = ~flag_q[pos_idx_q];
              flag_cnt_d        = flag_q[pos_idx_q] ? flag_cnt_q - CNT_W'(1)
                                                    : flag_cnt_q + CNT_W'(1);
            end
          end else begin
            pos_idx_d = move_cursor(pos_idx_q, cmd_up, cmd_down, cmd_left, cmd_right);
          end
        end
        GS_LOST, GS_WON: begin
          // Board frozen; the cursor stays live for the renderer.
          pos_idx_d = move_cursor(pos_idx_q, cmd_up, cmd_down, cmd_left, cmd_right);
        end
        default: begin
          state_d = GS_GEN;
        end
      endcase
    end

    busy_d               = (state_d == GS_GEN);
    pos_map_d            = '0;
    pos_map_d[pos_idx_d] = 1'b1;
  end

  assign mineMap    = mine_q;
  assign flagMap    = flag_q;
  assign stepMap    = step_q;
  assign posMap     = pos_map_q;
  assign game_state = state_q;
  assign busy       = busy_q;
  assign flag_count = flag_cnt_q;

endmodule

// File: tb/tb_minefield_ctrl.sv
// Scoreboard bench for minefield_ctrl: the driver updates a tile-level game
// model and queues the expected board after each command or generation;
// the monitor pops and compares whenever the DUT presents that board.
module tb_minefield_ctrl;

  localparam int unsigned NM   = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam logic [6:0] C_NG = 7'b1000000;
  localparam logic [6:0] C_ST = 7'b0100000;
  localparam logic [6:0] C_FL = 7'b0010000;
  localparam logic [6:0] C_UP = 7'b0001000;
  localparam logic [6:0] C_DN = 7'b0000100;
  localparam logic [6:0] C_LF = 7'b0000010;
  localparam logic [6:0] C_RT = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset, new_game, cmd_up, cmd_down, cmd_left, cmd_right, cmd_flag, cmd_step;
  logic [63:0] mineMap, flagMap, stepMap, posMap;
  logic [1:0]  game_state;
  logic        busy;
  logic [6:0]  flag_count;

  always #5 clk = ~clk;

  minefield_ctrl #(.NUM_MINES(NM), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .cmd_up(cmd_up), .cmd_down(cmd_down), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .cmd_flag(cmd_flag), .cmd_step(cmd_step),
    .mineMap(mineMap), .flagMap(flagMap), .stepMap(stepMap), .posMap(posMap),
    .game_state(game_state), .busy(busy), .flag_count(flag_count)
  );

  typedef struct packed {
    logic        gen;
    logic [1:0]  st;
    logic [63:0] mine;
    logic [63:0] flag;
    logic [63:0] step;
    logic [63:0] pos;
    logic [6:0]  cnt;
    logic [31:0] wt;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference game model
  logic [63:0] m_mine, m_flag, m_step;
  int          m_row, m_col, m_state, m_cnt;
  logic [15:0] m_lfsr;
  logic [63:0] g1_mines;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk) m_lfsr <= (!reset) ? SEED : lstep(m_lfsr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic push_exp(input string nm, input logic gen, input logic [31:0] wt);
    exp_t e;
    e.gen  = gen;
    e.st   = 2'(m_state);
    e.mine = m_mine;
    e.flag = m_flag;
    e.step = m_step;
    e.pos  = 64'd1 << (m_row * 8 + m_col);
    e.cnt  = 7'(m_cnt);
    e.wt   = wt;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  // Mines are the first NM distinct low-6-bit values of the LFSR sequence.
  task automatic plan_gen(input logic [15:0] start, input string nm);
    logic [15:0] v;
    int placed, last;
    v = start; placed = 0; last = 0; m_mine = '0;
    for (int i = 0; i < 65536 && placed < int'(NM); i++) begin
      if (m_mine[v[5:0]] == 1'b0) begin
        m_mine[v[5:0]] = 1'b1;
        placed++;
        last = i;
      end
      v = lstep(v);
    end
    m_state = 1;
    push_exp(nm, 1'b1, 32'(last + 1));
  endtask

  task automatic model_move(input logic up, dn, lf, rt);
    if (up)      m_row = (m_row + 7) % 8;
    else if (dn) m_row = (m_row + 1) % 8;
    else if (lf) m_col = (m_col + 7) % 8;
    else if (rt) m_col = (m_col + 1) % 8;
  endtask

  task automatic model_cmd(input logic st, fl, up, dn, lf, rt);
    int t;
    t = m_row * 8 + m_col;
    if (m_state == 1) begin
      if (st) begin
        if (!m_step[t] && !m_flag[t]) begin
          if (m_mine[t]) begin
            m_step  = m_step | m_mine;
            m_state = 2;
          end else begin
            m_step[t] = 1'b1;
            if ($countones(m_step & ~m_mine) == 64 - int'(NM)) m_state = 3;
          end
        end
      end else if (fl) begin
        if (!m_step[t]) begin
          m_flag[t] = ~m_flag[t];
          m_cnt     = m_flag[t] ? m_cnt + 1 : m_cnt - 1;
        end
      end else begin
        model_move(up, dn, lf, rt);
      end
    end else if (m_state >= 2) begin
      model_move(up, dn, lf, rt);
    end
  endtask

  task automatic clear_cmds();
    {new_game, cmd_step, cmd_flag, cmd_up, cmd_down, cmd_left, cmd_right} = 7'b0;
  endtask

  task automatic issue(input logic [6:0] c, input string nm);
    @(negedge clk);
    {new_game, cmd_step, cmd_flag, cmd_up, cmd_down, cmd_left, cmd_right} = c;
    if (c[6]) begin
      m_flag = '0; m_step = '0; m_mine = '0;
      m_row = 0; m_col = 0; m_cnt = 0; m_state = 0;
      push_exp(nm, 1'b0, 32'd0);
      plan_gen(lstep(m_lfsr), {nm, ".gen"});
    end else begin
      model_cmd(c[5], c[4], c[3], c[2], c[1], c[0]);
      push_exp(nm, 1'b0, 32'd0);
    end
    @(posedge clk);
    #2;
    clear_cmds();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    clear_cmds();
    repeat (cycles - 1) @(negedge clk);
    m_mine = '0; m_flag = '0; m_step = '0;
    m_row = 0; m_col = 0; m_cnt = 0; m_state = 0;
    push_exp("reset", 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    plan_gen(SEED, "reset.gen");
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (game_state !== 2'd1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (game_state !== 2'd1) begin
      chk("play_timeout", 64'(game_state), 64'd1);
      finish_run();
    end
  endtask

  task automatic move_to(input int tgt);
    while (m_col != tgt % 8) issue(C_RT, "mv_right");
    while (m_row != tgt / 8) issue(C_DN, "mv_down");
  endtask

  function automatic int pick_safe();
    int t;
    do t = int'($urandom_range(63)); while (m_mine[t] || m_step[t] || m_flag[t]);
    return t;
  endfunction

  // Monitor: per-cycle invariants plus scoreboard pops.
  int gen_wait = 0;
  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    chk("pos_onehot", 64'($countones(posMap)), 64'd1);
    if (game_state == 2'd1) begin
      chk("flag_step_disjoint", flagMap & stepMap, 64'd0);
      chk("play_mine_count", 64'($countones(mineMap)), 64'(NM));
    end
    if (sb.size() != 0) begin
      if (!sb[0].gen || game_state == 2'd1) begin
        e  = sb.pop_front();
        nm = sb_nm.pop_front();
        chk({nm, ".state"}, 64'(game_state), 64'(e.st));
        chk({nm, ".busy"},  64'(busy), 64'(e.st == 2'd0));
        chk({nm, ".mine"},  mineMap, e.mine);
        chk({nm, ".flag"},  flagMap, e.flag);
        chk({nm, ".step"},  stepMap, e.step);
        chk({nm, ".pos"},   posMap,  e.pos);
        chk({nm, ".cnt"},   64'(flag_count), 64'(e.cnt));
        if (e.gen) chk({nm, ".gen_cycles"}, 64'(gen_wait), 64'(e.wt));
        gen_wait = 0;
      end else begin
        gen_wait++;
        chk("busy_in_gen", 64'(busy), 64'd1);
        if (gen_wait > 2000) begin
          e  = sb.pop_front();
          nm = sb_nm.pop_front();
          chk({nm, ".gen_timeout"}, 64'(gen_wait), 64'(e.wt));
          gen_wait = 0;
        end
      end
    end
  end

  initial begin
    int t1, t2, t3, tm;
    int safe_q[$];
    logic [63:0] frozen_step, frozen_flag;

    reset = 1'b0;
    clear_cmds();

    // Game 1: generation from seed, cursor wrap, flag/step interaction
    do_reset(3);
    wait_play();
    g1_mines = m_mine;
    chk("gen_popcount", 64'($countones(mineMap)), 64'(NM));

    issue(C_LF, "wrap_left");  chk("wrap_left_pos",  posMap, 64'h0000_0000_0000_0080);
    issue(C_UP, "wrap_up");    chk("wrap_up_pos",    posMap, 64'h8000_0000_0000_0000);
    issue(C_RT, "wrap_right"); chk("wrap_right_pos", posMap, 64'h0100_0000_0000_0000);
    issue(C_DN, "wrap_down");  chk("wrap_down_pos",  posMap, 64'h0000_0000_0000_0001);

    t1 = pick_safe();
    move_to(t1);
    issue(C_FL, "flag1");        chk("flag_set", 64'(flagMap[t1]), 64'd1);
                                 chk("flag_cnt1", 64'(flag_count), 64'd1);
    issue(C_ST, "step_on_flag"); chk("step_blocked", 64'(stepMap[t1]), 64'd0);
    issue(C_FL, "unflag");       chk("flag_clr", 64'(flagMap[t1]), 64'd0);
                                 chk("flag_cnt0", 64'(flag_count), 64'd0);
    issue(C_ST, "step1");        chk("step_set", 64'(stepMap[t1]), 64'd1);
    issue(C_FL, "flag_on_step"); chk("flag_blocked", 64'(flagMap[t1]), 64'd0);

    t2 = pick_safe();
    move_to(t2);
    issue(C_ST | C_RT, "step_and_right");
    chk("prio_pos",  posMap, 64'd1 << t2);
    chk("prio_step", 64'(stepMap[t2]), 64'd1);

    t3 = pick_safe();
    move_to(t3);
    issue(C_FL, "flag3");
    repeat ($urandom_range(1, 40)) @(negedge clk);

    // Game 2: new_game mid-play, then clear all safe tiles
    issue(C_NG, "newgame_play");
    chk("ng_state", 64'(game_state), 64'd0);
    chk("ng_maps",  mineMap | flagMap | stepMap, 64'd0);
    chk("ng_pos",   posMap, 64'd1);
    chk("ng_cnt",   64'(flag_count), 64'd0);
    wait_play();
    chk("layout_differs", 64'(mineMap != g1_mines), 64'd1);

    for (int i = 0; i < 64; i++) if (!m_mine[i]) safe_q.push_back(i);
    for (int i = safe_q.size() - 1; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i));
      tmp = safe_q[i]; safe_q[i] = safe_q[j]; safe_q[j] = tmp;
    end
    foreach (safe_q[i]) begin
      move_to(safe_q[i]);
      issue(C_ST, "win_step");
      if (i == safe_q.size() - 2) chk("not_won_yet", 64'(game_state), 64'd1);
    end
    chk("won", 64'(game_state), 64'd3);
    issue(C_RT, "won_move");
    issue(C_ST, "won_step");
    chk("won_state_held", 64'(game_state), 64'd3);

    // Game 3: loss on a mine, board then frozen
    issue(C_NG, "newgame_won");
    wait_play();
    do tm = int'($urandom_range(63)); while (!m_mine[tm]);
    move_to(tm);
    issue(C_ST, "step_mine");
    chk("lost", 64'(game_state), 64'd2);
    chk("reveal_all", stepMap & m_mine, m_mine);
    frozen_step = m_step;
    frozen_flag = m_flag;
    issue(C_RT, "lost_move");
    issue(C_ST, "lost_step");
    issue(C_FL, "lost_flag");
    chk("lost_frozen_step", stepMap, frozen_step);
    chk("lost_frozen_flag", flagMap, frozen_flag);

    // Randomized play against the model
    issue(C_NG, "newgame_rand");
    wait_play();
    for (int n = 0; n < 600; n++) begin
      if (m_state == 1) begin
        logic [6:0] c;
        c = '0;
        for (int b = 0; b < 6; b++) c[b] = ($urandom_range(3) == 0);
        issue(c, "rand_cmd");
      end else begin
        issue(C_NG, "rand_newgame");
        wait_play();
      end
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // Mid-game reset reloads the seed, so the first layout returns
    if (m_state != 1) begin
      issue(C_NG, "pre_reset_ng");
      wait_play();
    end
    issue(C_DN, "pre_reset_move");
    do_reset(2);
    wait_play();
    chk("reseed_layout", mineMap, g1_mines);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    finish_run();
  end

endmodule
